mem_loader: RTL and testbench

Program loader that writes an external byte stream into RAM through the shared 16-bit bus while the CPU is parked. It requests bus ownership from the controller with a hold/acknowledge handshake. It then sequences the memory block's MAR and RAM strobes for each byte and releases the bus after the last byte. Top level muxes `bus_out` onto the bus when `bus_drive` is high and ORs the strobes into the controller's control word.

---
 rtl/mem_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_loader: writes an external byte stream into RAM over the shared bus   |
// | while the CPU is parked. Optional readback verify: LOADER_VERIFY_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_loader (
   input  logic        clk,
   input  logic        rst,
   output logic        hold_req,
   input  logic        hold_ack,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_last,
   output logic [15:0] bus_out,
   output logic        bus_drive,
   input  logic [15:0] bus_in,
   output logic        mar_loadh,
   output logic        mar_loadl,
   output logic        ram_load,
   output logic        mdr_load,
   output logic        mdr_en,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [3:0] c_st_idle  = 4'd0;
   localparam logic [3:0] c_st_req   = 4'd1;
   localparam logic [3:0] c_st_grant = 4'd2;
   localparam logic [3:0] c_st_marh  = 4'd3;
   localparam logic [3:0] c_st_marl  = 4'd4;
   localparam logic [3:0] c_st_write = 4'd5;
   localparam logic [3:0] c_st_rel   = 4'd6;
`ifdef LOADER_VERIFY_EN
   localparam logic [3:0] c_st_rdl   = 4'd7;
   localparam logic [3:0] c_st_rdc   = 4'd8;
`endif

   logic [3:0]  r_state;
   logic [3:0]  w_state_nxt;
   logic [15:0] r_addr;
   logic [7:0]  r_data;
   logic        r_last;
   logic [7:0]  r_cache_hi;
   logic        r_cache_vld;
   logic        r_err;
   logic        w_in_xfer;
   logic        w_abort;
   logic        w_accept;
   logic        w_page_hit;

   // States in which the bus is owned; losing hold_ack here aborts the transfer
   always_comb begin
      w_in_xfer = 1'b0;
      case (r_state)
         c_st_grant, c_st_marh, c_st_marl, c_st_write: w_in_xfer = 1'b1;
`ifdef LOADER_VERIFY_EN
         c_st_rdl, c_st_rdc:                           w_in_xfer = 1'b1;
`endif
         default:                                      w_in_xfer = 1'b0;
      endcase
   end

   assign w_abort    = w_in_xfer & ~hold_ack;
   assign w_accept   = (r_state == c_st_grant) & cmd_valid & hold_ack;
   assign w_page_hit = r_cache_vld & (cmd_addr[15:8] == r_cache_hi);

`ifdef LOADER_VERIFY_EN
   logic w_unused_bus;
   assign w_unused_bus = ^bus_in[15:8];
`else
   logic w_unused_bus;
   assign w_unused_bus = ^bus_in;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (cmd_valid) begin
               w_state_nxt = c_st_req;
            end
         end
         c_st_req: begin
            if (hold_ack) begin
               w_state_nxt = c_st_grant;
            end
         end
         c_st_grant: begin
            if (cmd_valid) begin
               w_state_nxt = w_page_hit ? c_st_marl : c_st_marh;
            end
         end
         c_st_marh: begin
            w_state_nxt = c_st_marl;
         end
         c_st_marl: begin
            w_state_nxt = c_st_write;
         end
         c_st_write: begin
`ifdef LOADER_VERIFY_EN
            w_state_nxt = c_st_rdl;
`else
            w_state_nxt = r_last ? c_st_rel : c_st_grant;
`endif
         end
`ifdef LOADER_VERIFY_EN
         c_st_rdl: begin
            w_state_nxt = c_st_rdc;
         end
         c_st_rdc: begin
            w_state_nxt = r_last ? c_st_rel : c_st_grant;
         end
`endif
         c_st_rel: begin
            w_state_nxt = c_st_idle;
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
      // An abort overrides any normal progression, including a GRANT handshake
      if (w_abort) begin
         w_state_nxt = c_st_rel;
      end
   end

   // Command latch, high-byte cache and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr      <= 16'h0000;
         r_data      <= 8'h00;
         r_last      <= 1'b0;
         r_cache_hi  <= 8'h00;
         r_cache_vld <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= cmd_addr;
            r_data <= cmd_data;
            r_last <= cmd_last;
         end
         case (r_state)
            c_st_idle: begin
               if (cmd_valid) begin
                  r_err       <= 1'b0;
                  r_cache_vld <= 1'b0;
               end
            end
            c_st_marh: begin
               r_cache_hi  <= r_addr[15:8];
               r_cache_vld <= 1'b1;
            end
            c_st_rel: begin
               r_cache_vld <= 1'b0;
            end
`ifdef LOADER_VERIFY_EN
            c_st_rdc: begin
               if (bus_in[7:0] != r_data) begin
                  r_err <= 1'b1;
               end
            end
`endif
            default: begin
            end
         endcase
         if (w_abort) begin
            r_err <= 1'b1;
         end
      end
   end

   // Moore output decode
   always_comb begin
      hold_req  = 1'b0;
      cmd_ready = 1'b0;
      bus_out   = 16'h0000;
      bus_drive = 1'b0;
      mar_loadh = 1'b0;
      mar_loadl = 1'b0;
      ram_load  = 1'b0;
      mdr_load  = 1'b0;
      mdr_en    = 1'b0;
      done      = 1'b0;
      busy      = (r_state != c_st_idle);
      err       = r_err;
      case (r_state)
         c_st_req: begin
            hold_req = 1'b1;
         end
         c_st_grant: begin
            hold_req  = 1'b1;
            cmd_ready = 1'b1;
         end
         c_st_marh: begin
            hold_req  = 1'b1;
            bus_drive = 1'b1;
            bus_out   = {8'h00, r_addr[15:8]};
            mar_loadh = 1'b1;
         end
         c_st_marl: begin
            hold_req  = 1'b1;
            bus_drive = 1'b1;
            bus_out   = {8'h00, r_addr[7:0]};
            mar_loadl = 1'b1;
         end
         c_st_write: begin
            hold_req  = 1'b1;
            bus_drive = 1'b1;
            bus_out   = {8'h00, r_data};
            ram_load  = 1'b1;
         end
`ifdef LOADER_VERIFY_EN
         c_st_rdl: begin
            hold_req = 1'b1;
            mdr_load = 1'b1;
         end
         c_st_rdc: begin
            hold_req = 1'b1;
            mdr_en   = 1'b1;
         end
`endif
         c_st_rel: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_loader: directed self-checking bench for mem_loader.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_loader;

   logic        clk;
   logic        rst;
   logic        hold_req;
   logic        hold_ack;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_data;
   logic        cmd_last;
   logic [15:0] bus_out;
   logic        bus_drive;
   logic [15:0] bus_in;
   logic        mar_loadh;
   logic        mar_loadl;
   logic        ram_load;
   logic        mdr_load;
   logic        mdr_en;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;
   int cnt_marh = 0;
   int cnt_ram  = 0;
   int cnt_done = 0;
   int snap_marh;
   int snap_ram;
   int snap_done;

   logic [4:0]  strb;
   logic [26:0] all_out;
   assign strb    = {mar_loadh, mar_loadl, ram_load, mdr_load, mdr_en};
   assign all_out = {hold_req, cmd_ready, bus_drive, strb, busy, done, err, bus_out};

   mem_loader dut (
      .clk       (clk),
      .rst       (rst),
      .hold_req  (hold_req),
      .hold_ack  (hold_ack),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .cmd_last  (cmd_last),
      .bus_out   (bus_out),
      .bus_drive (bus_drive),
      .bus_in    (bus_in),
      .mar_loadh (mar_loadh),
      .mar_loadl (mar_loadl),
      .ram_load  (ram_load),
      .mdr_load  (mdr_load),
      .mdr_en    (mdr_en),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) begin
         if (mar_loadh) cnt_marh = cnt_marh + 1;
         if (ram_load)  cnt_ram  = cnt_ram + 1;
         if (done)      cnt_done = cnt_done + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called while the loader sits in GRANT; returns one cycle after the last data-phase state
   task automatic do_byte(input logic [15:0] a, input logic [7:0] d, input logic l,
                          input logic hit, input logic [7:0] rb);
      cmd_addr  = a;
      cmd_data  = d;
      cmd_last  = l;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      if (!hit) begin
         chk("marh_strobe", {27'd0, strb}, {27'd0, 5'b10000});
         chk("marh_bus", {15'd0, bus_drive, bus_out}, {15'd0, 1'b1, 8'h00, a[15:8]});
         tick();
      end
      chk("marl_strobe", {27'd0, strb}, {27'd0, 5'b01000});
      chk("marl_bus", {15'd0, bus_drive, bus_out}, {15'd0, 1'b1, 8'h00, a[7:0]});
      tick();
      chk("write_strobe", {27'd0, strb}, {27'd0, 5'b00100});
      chk("write_bus", {15'd0, bus_drive, bus_out}, {15'd0, 1'b1, 8'h00, d});
`ifdef LOADER_VERIFY_EN
      bus_in = {8'h00, rb};
      tick();
      chk("rdl_strobe", {27'd0, strb}, {27'd0, 5'b00010});
      chk("rdl_drive", {31'd0, bus_drive}, 32'd0);
      tick();
      chk("rdc_strobe", {27'd0, strb}, {27'd0, 5'b00001});
      chk("rdc_drive", {15'd0, bus_drive, bus_out}, 32'd0);
`else
      bus_in = {8'h00, rb};
`endif
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      hold_ack  = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = 16'h0000;
      cmd_data  = 8'h00;
      cmd_last  = 1'b0;
      bus_in    = 16'h0000;
      #1;
      chk("reset_outputs", {5'd0, all_out}, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Idle with no command: everything stays quiet
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_quiet", {5'd0, all_out}, 32'd0);
      end

      // Single byte 0x1234 <- 0xA5, hold_ack two cycles after hold_req
      snap_done = cnt_done;
      snap_marh = cnt_marh;
      cmd_addr  = 16'h1234;
      cmd_data  = 8'hA5;
      cmd_last  = 1'b1;
      cmd_valid = 1'b1;
      tick();
      chk("start_hold_req", {29'd0, hold_req, busy, cmd_ready}, {29'd0, 3'b110});
      tick();
      tick();
      hold_ack = 1'b1;
      chk("req_wait", {30'd0, hold_req, cmd_ready}, {30'd0, 2'b10});
      tick();
      chk("grant_ready", {30'd0, hold_req, cmd_ready}, {30'd0, 2'b11});
      do_byte(16'h1234, 8'hA5, 1'b1, 1'b0, 8'hA5);
      chk("rel_single", {28'd0, hold_req, done, err, bus_drive}, {28'd0, 4'b0100});
      hold_ack = 1'b0;
      tick();
      chk("idle_after_single", {29'd0, busy, done, hold_req}, 32'd0);
      chk("single_done_count", cnt_done - snap_done, 32'd1);
      chk("single_marh_count", cnt_marh - snap_marh, 32'd1);

      // Three bytes: 0x0200 miss, 0x0201 hit, pause, 0x0300 miss
      snap_marh = cnt_marh;
      snap_ram  = cnt_ram;
      hold_ack  = 1'b1;
      cmd_addr  = 16'h0200;
      cmd_valid = 1'b1;
      tick();
      tick();
      chk("grant3", {31'd0, cmd_ready}, 32'd1);
      do_byte(16'h0200, 8'h11, 1'b0, 1'b0, 8'h11);
      chk("back_to_grant1", {30'd0, cmd_ready, hold_req}, {30'd0, 2'b11});
      do_byte(16'h0201, 8'h22, 1'b0, 1'b1, 8'h22);
      chk("hit_3cyc_grant", {30'd0, cmd_ready, hold_req}, {30'd0, 2'b11});
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_in_grant", {24'd0, cmd_ready, hold_req, bus_drive, strb},
             {24'd0, 1'b1, 1'b1, 1'b0, 5'b00000});
      end
      do_byte(16'h0300, 8'h33, 1'b1, 1'b0, 8'h33);
      chk("rel3", {29'd0, hold_req, done, err}, {29'd0, 3'b010});
      chk("marh_count3", cnt_marh - snap_marh, 32'd2);
      chk("ram_count3", cnt_ram - snap_ram, 32'd3);
      tick();
      chk("idle3", {31'd0, busy}, 32'd0);

      // hold_ack lost during MARL: abort straight to REL with err
      snap_ram  = cnt_ram;
      snap_done = cnt_done;
      cmd_addr  = 16'h0405;
      cmd_data  = 8'h77;
      cmd_last  = 1'b1;
      cmd_valid = 1'b1;
      tick();
      tick();
      chk("abort_grant", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("abort_marh", {27'd0, strb}, {27'd0, 5'b10000});
      tick();
      chk("abort_marl", {27'd0, strb}, {27'd0, 5'b01000});
      hold_ack = 1'b0;
      tick();
      chk("abort_rel", {25'd0, err, done, hold_req, bus_drive, ram_load, busy, cmd_ready},
          {25'd0, 7'b1100010});
      tick();
      chk("abort_idle_err", {29'd0, err, busy, done}, {29'd0, 3'b100});
      chk("abort_no_write", cnt_ram - snap_ram, 32'd0);
      chk("abort_done_once", cnt_done - snap_done, 32'd1);

      // A new start clears the sticky error
      cmd_valid = 1'b1;
      tick();
      chk("restart_clears_err", {30'd0, err, hold_req}, {30'd0, 2'b01});
      hold_ack = 1'b1;
      tick();
      do_byte(16'h0405, 8'h77, 1'b1, 1'b0, 8'h77);
      chk("restart_rel", {30'd0, done, err}, {30'd0, 2'b10});
      tick();

`ifdef LOADER_VERIFY_EN
      // Readback mismatch sets err and it stays set in IDLE
      cmd_addr  = 16'h0500;
      cmd_data  = 8'h3C;
      cmd_last  = 1'b1;
      cmd_valid = 1'b1;
      tick();
      tick();
      do_byte(16'h0500, 8'h3C, 1'b1, 1'b0, 8'h3D);
      chk("verify_rel_err", {30'd0, done, err}, {30'd0, 2'b11});
      tick();
      chk("verify_idle_err", {30'd0, err, busy}, {30'd0, 2'b10});
`endif

      // Asynchronous reset mid-transfer
      cmd_addr  = 16'h0600;
      cmd_data  = 8'h44;
      cmd_last  = 1'b1;
      cmd_valid = 1'b1;
      tick();
      tick();
      tick();
      cmd_valid = 1'b0;
      chk("pre_reset_marh", {31'd0, mar_loadh}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", {5'd0, all_out}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_reset_idle", {5'd0, all_out}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
